// File: rtl/seq_divider_64_bit_pkg.sv
// Shared definitions for the sequential divider: state encoding and result constants.
package seq_divider_64_bit_pkg;

    localparam int unsigned DIV_WIDTH = 64;

    // Every quotient bit takes this value when the divisor is zero.
    localparam logic DBZ_QUOTIENT_BIT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/seq_divider_64_bit_trial_sub.sv
// One restoring-division step: difference and borrow of shifted - divisor.
module div_trial_sub #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] shifted,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] difference,
    output logic             borrow
);

    logic carry_s;

    // Two's-complement subtract; a missing carry out means shifted < divisor.
    always_comb begin
        {carry_s, difference} = {1'b0, shifted} + {1'b0, ~divisor} + {{WIDTH{1'b0}}, 1'b1};
        borrow = ~carry_s;
    end

endmodule

// File: rtl/seq_divider_64_bit.sv
// Unsigned restoring divider producing one quotient bit per clock, start/done handshake.
module seq_divider_64_bit
    import seq_divider_64_bit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    div_state_e       state_q;
    logic [CW-1:0]    cnt_q;
    // Before step i the partial remainder is below 2**(i-1), so its MSB is always zero.
    logic [WIDTH-2:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;

    logic [WIDTH-1:0] shifted_s;
    logic [WIDTH-1:0] diff_s;
    logic             borrow_s;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;

    div_trial_sub #(.WIDTH(WIDTH)) u_trial (
        .shifted    (shifted_s),
        .divisor    (dvs_q),
        .difference (diff_s),
        .borrow     (borrow_s)
    );

    // Next partial remainder and quotient for the current iteration.
    always_comb begin
        shifted_s = {rem_q, quo_q[WIDTH-1]};
        if (borrow_s) begin
            rem_d = shifted_s;
        end else begin
            rem_d = diff_s;
        end
        quo_d = {quo_q[WIDTH-2:0], ~borrow_s};
    end

    // Control FSM, iteration datapath and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CW{1'b0}};
            rem_q       <= {(WIDTH-1){1'b0}};
            quo_q       <= {WIDTH{1'b0}};
            dvs_q       <= {WIDTH{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= {WIDTH{1'b0}};
            remainder_q <= {WIDTH{1'b0}};
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    busy_q <= 1'b0;
                    if (start) begin
                        if (divisor == {WIDTH{1'b0}}) begin
                            state_q     <= ST_DONE;
                            done_q      <= 1'b1;
                            dbz_q       <= 1'b1;
                            quotient_q  <= {WIDTH{DBZ_QUOTIENT_BIT}};
                            remainder_q <= dividend;
                        end else begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                            dvs_q   <= divisor;
                            rem_q   <= {(WIDTH-1){1'b0}};
                            quo_q   <= dividend;
                            cnt_q   <= CW'(WIDTH);
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    rem_q <= rem_d[WIDTH-2:0];
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q     <= ST_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        dbz_q       <= 1'b0;
                        quotient_q  <= quo_d;
                        remainder_q <= rem_d;
                    end else begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;

endmodule
